// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller built around a single full-adder
// cell. One operand bit is consumed per clock, LSB first, so an operation spans
// WIDTH clocks of RUN, then one DONE cycle before returning to IDLE.
// Optional feature: define SERIAL_ADD_SUB_EN to add a 'sub' input that turns
// the operation into a - b (two's complement via inverted b and carry-in 1).

module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // One extra counter bit so the count cannot wrap inside an operation.
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             accept_s;
   logic             last_bit_s;
   logic             fa_s_s;
   logic             fa_co_s;
   logic [WIDTH-1:0] b_load_s;
   logic             c_load_s;

   // The single full-adder cell, fed by the operand LSBs and the carry register.
   fa u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (fa_s_s),
      .cout (fa_co_s)
   );

   // Handshake decode: start only counts in IDLE; the last bit is count WIDTH-1.
   always_comb begin
      accept_s   = (state_q == IDLE) && start;
      last_bit_s = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
   end

   // Operand b and carry-in as loaded at acceptance (inverted b and carry 1 for subtract).
   always_comb begin
      b_load_s = b;
      c_load_s = cin;
`ifdef SERIAL_ADD_SUB_EN
      if (sub) begin
         b_load_s = ~b;
         c_load_s = 1'b1;
      end else begin
         b_load_s = b;
         c_load_s = cin;
      end
`endif
   end

   // State register and all datapath/output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after last bit, DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
            else       state_d = IDLE;
         end
         RUN: begin
            if (last_bit_s) state_d = DONE;
            else            state_d = RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Serial datapath: load on acceptance, shift one bit per RUN cycle, hold otherwise.
   always_comb begin
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      if (accept_s) begin
         a_sh_d  = a;
         b_sh_d  = b_load_s;
         res_d   = '0;
         carry_d = c_load_s;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
         b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
         res_d   = {fa_s_s, res_q[WIDTH-1:1]};
         carry_d = fa_co_s;
         cnt_d   = cnt_q + CW'(1);
      end else begin
         a_sh_d  = a_sh_q;
         b_sh_d  = b_sh_q;
         res_d   = res_q;
         carry_d = carry_q;
         cnt_d   = cnt_q;
      end
   end

   // Output logic: busy spans accept..last bit; results publish on the edge entering DONE.
   always_comb begin
      busy_d = 1'b0;
      done_d = last_bit_s;
      sum_d  = sum_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      case (state_q)
         IDLE:    busy_d = start;
         RUN:     busy_d = ~last_bit_s;
         DONE:    busy_d = 1'b0;
         default: busy_d = 1'b0;
      endcase
      if (last_bit_s) begin
         sum_d  = {fa_s_s, res_q[WIDTH-1:1]};
         cout_d = fa_co_s;
         // carry_q here is the carry into the MSB.
         ovf_d  = carry_q ^ fa_co_s;
      end else begin
         sum_d  = sum_q;
         cout_d = cout_q;
         ovf_d  = ovf_q;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). Expected results come from
// plain integer arithmetic on the operands; timing expectations come from the
// operation length (WIDTH edges to done, WIDTH+2 cycles per back-to-back op).

module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation from IDLE and checks latency, busy length, results.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic tc, input bit tsub, input bit repulse,
                        input string name);
      logic [W-1:0] eb;
      logic         ec;
      logic [W:0]   full;
      logic [W-1:0] es;
      logic         eco;
      logic         eov;
      int           busy_cnt;
      int           done_cycle;
      int           ndone;
      eb   = tsub ? ~tbv : tbv;
      ec   = tsub ? 1'b1 : tc;
      full = {1'b0, ta} + {1'b0, eb} + {{W{1'b0}}, ec};
      es   = full[W-1:0];
      eco  = full[W];
      eov  = (ta[W-1] == eb[W-1]) && (es[W-1] != ta[W-1]);

      a = ta; b = tbv; cin = tc; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub = tsub;
`endif
      step();
      start = 1'b0;
      busy_cnt   = (busy === 1'b1) ? 1 : 0;
      done_cycle = -1;
      ndone      = 0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s accept_busy: got %b want 1", name, busy);
      end
      for (int i = 1; i <= W + 2; i++) begin
         a   = W'($urandom);
         b   = W'($urandom);
         cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         sub = 1'($urandom);
`endif
         if (repulse && i == 3) begin
            start = 1'b1;
            a     = 8'h11;
         end else begin
            start = 1'b0;
         end
         step();
         if (done === 1'b1) begin
            ndone++;
            if (done_cycle < 0) done_cycle = i;
            checks++;
            if (sum !== es) begin
               errors++;
               $display("FAIL %s sum: got %h want %h", name, sum, es);
            end
            checks++;
            if (cout !== eco) begin
               errors++;
               $display("FAIL %s cout: got %b want %b", name, cout, eco);
            end
            checks++;
            if (ovf !== eov) begin
               errors++;
               $display("FAIL %s ovf: got %b want %b", name, ovf, eov);
            end
         end
         if (busy === 1'b1) busy_cnt++;
      end
      start = 1'b0;
      checks++;
      if (ndone != 1) begin
         errors++;
         $display("FAIL %s done_count: got %0d want 1", name, ndone);
      end
      checks++;
      if (done_cycle != W) begin
         errors++;
         $display("FAIL %s done_latency: got %0d want %0d", name, done_cycle, W);
      end
      checks++;
      if (busy_cnt != W) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, W);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_busy: got %b want 0", name, busy);
      end
      checks++;
      if (sum !== es) begin
         errors++;
         $display("FAIL %s sum_held: got %h want %h", name, sum, es);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      step();
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++;
      if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
      checks++;
      if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      rst = 1'b0; start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority_busy: got %b want 0", busy); end
   endtask

   task automatic test_spec_vectors();
      do_op(8'h3C, 8'h45, 1'b0, 1'b0, 1'b0, "add_3c_45");
      do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_ff_01");
      do_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, "add_7f_cin");
   endtask

   task automatic test_restart_ignored();
      do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, "restart_ignored");
   endtask

   task automatic test_abort();
      int ndone;
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      step();
      start = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      checks++;
      if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum: got %h want 00", sum); end
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) ndone++;
         step();
      end
      checks++;
      if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
      checks++;
      if (sum !== 8'h00) begin errors++; $display("FAIL abort_sum_held: got %h want 00", sum); end
      do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      int           t[$];
      logic [W-1:0] ta;
      logic [W-1:0] tbv;
      logic         tc;
      logic [W:0]   full;
      ta = W'($urandom); tbv = W'($urandom); tc = 1'($urandom);
      full = {1'b0, ta} + {1'b0, tbv} + {{W{1'b0}}, tc};
      a = ta; b = tbv; cin = tc; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      step();
      for (int i = 1; i <= 30; i++) begin
         step();
         if (done === 1'b1) begin
            t.push_back(i);
            checks++;
            if ({cout, sum} !== full) begin
               errors++;
               $display("FAIL b2b_result: got %b%h want %h", cout, sum, full);
            end
         end
      end
      start = 1'b0;
      repeat (12) step();
      checks++;
      if (t.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 3", t.size());
      end else begin
         checks++;
         if (t[0] != W) begin errors++; $display("FAIL b2b_first: got %0d want %0d", t[0], W); end
         checks++;
         if (t[1] - t[0] != W + 2) begin errors++; $display("FAIL b2b_gap1: got %0d want %0d", t[1] - t[0], W + 2); end
         checks++;
         if (t[2] - t[1] != W + 2) begin errors++; $display("FAIL b2b_gap2: got %0d want %0d", t[2] - t[1], W + 2); end
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy: got %b want 0", busy); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 16; k++) begin
`ifdef SERIAL_ADD_SUB_EN
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, "random");
`else
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0, "random");
`endif
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      do_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, "sub_05_07");
      do_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0, "sub_07_05");
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b0;
`endif
      test_reset();
      test_spec_vectors();
      test_restart_ignored();
      test_abort();
      test_back_to_back();
      test_random();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
